// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use hazard detection and bubble insertion.
// Latency: one cycle ID->EX; load-use adds LOAD_LATENCY cycles; mem_stall holds EX and stalls ID; flush overrides all.
module id_ex_stage #(
  parameter int unsigned LOAD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [15:0] id_pc,
  input  logic [3:0]  id_opcode,
  input  logic [15:0] id_sr1,
  input  logic [15:0] id_sr2,
  input  logic [2:0]  id_sr1_addr,
  input  logic [2:0]  id_sr2_addr,
  input  logic        id_sr1_used,
  input  logic        id_sr2_used,
  input  logic [2:0]  id_dest,
  input  logic        id_dest_we,
  input  logic        id_is_load,
  input  logic        mem_stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [15:0] ex_pc,
  output logic [3:0]  ex_opcode,
  output logic [15:0] ex_sr1,
  output logic [15:0] ex_sr2,
  output logic [2:0]  ex_sr1_addr,
  output logic [2:0]  ex_sr2_addr,
  output logic [2:0]  ex_dest,
  output logic        ex_dest_we,
  output logic        ex_is_load,
  output logic        id_stall
);

  typedef enum logic {RUN, BUBBLE} state_e;

  localparam logic [2:0] CNT_INIT = 3'(LOAD_LATENCY - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ex_valid_q, ex_valid_d;
  logic [15:0] ex_pc_q, ex_pc_d;
  logic [3:0]  ex_opcode_q, ex_opcode_d;
  logic [15:0] ex_sr1_q, ex_sr1_d;
  logic [15:0] ex_sr2_q, ex_sr2_d;
  logic [2:0]  ex_sr1_addr_q, ex_sr1_addr_d;
  logic [2:0]  ex_sr2_addr_q, ex_sr2_addr_d;
  logic [2:0]  ex_dest_q, ex_dest_d;
  logic        ex_dest_we_q, ex_dest_we_d;
  logic        ex_is_load_q, ex_is_load_d;
  logic        hazard;
  logic        load_bubble;
  logic        capture;

  // R0 is an ordinary register here, so address 0 is compared like any other.
  assign hazard = id_valid & ex_valid_q & ex_is_load_q & ex_dest_we_q &
                  ((id_sr1_used & (id_sr1_addr == ex_dest_q)) |
                   (id_sr2_used & (id_sr2_addr == ex_dest_q)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_stall    = 1'b0;
    load_bubble = 1'b0;
    capture     = 1'b0;
    if (flush) begin
      load_bubble = 1'b1;
      state_d     = RUN;
      cnt_d       = 3'd0;
    end else if (mem_stall) begin
      id_stall = 1'b1;
    end else if (state_q == BUBBLE) begin
      load_bubble = 1'b1;
      id_stall    = 1'b1;
      cnt_d       = cnt_q - 3'd1;
      if (cnt_q == 3'd1) state_d = RUN;
    end else if (hazard) begin
      load_bubble = 1'b1;
      id_stall    = 1'b1;
      if (LOAD_LATENCY > 1) begin
        state_d = BUBBLE;
        cnt_d   = CNT_INIT;
      end
    end else if (id_valid) begin
      capture = 1'b1;
    end else begin
      load_bubble = 1'b1;
    end
  end

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_opcode_d   = ex_opcode_q;
    ex_sr1_d      = ex_sr1_q;
    ex_sr2_d      = ex_sr2_q;
    ex_sr1_addr_d = ex_sr1_addr_q;
    ex_sr2_addr_d = ex_sr2_addr_q;
    ex_dest_d     = ex_dest_q;
    ex_dest_we_d  = ex_dest_we_q;
    ex_is_load_d  = ex_is_load_q;
    if (load_bubble) begin
      ex_valid_d    = 1'b0;
      ex_pc_d       = 16'd0;
      ex_opcode_d   = 4'd0;
      ex_sr1_d      = 16'd0;
      ex_sr2_d      = 16'd0;
      ex_sr1_addr_d = 3'd0;
      ex_sr2_addr_d = 3'd0;
      ex_dest_d     = 3'd0;
      ex_dest_we_d  = 1'b0;
      ex_is_load_d  = 1'b0;
    end else if (capture) begin
      ex_valid_d    = 1'b1;
      ex_pc_d       = id_pc;
      ex_opcode_d   = id_opcode;
      ex_sr1_d      = id_sr1;
      ex_sr2_d      = id_sr2;
      ex_sr1_addr_d = id_sr1_addr;
      ex_sr2_addr_d = id_sr2_addr;
      ex_dest_d     = id_dest;
      ex_dest_we_d  = id_dest_we;
      ex_is_load_d  = id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cnt_q         <= 3'd0;
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= 16'd0;
      ex_opcode_q   <= 4'd0;
      ex_sr1_q      <= 16'd0;
      ex_sr2_q      <= 16'd0;
      ex_sr1_addr_q <= 3'd0;
      ex_sr2_addr_q <= 3'd0;
      ex_dest_q     <= 3'd0;
      ex_dest_we_q  <= 1'b0;
      ex_is_load_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_opcode_q   <= ex_opcode_d;
      ex_sr1_q      <= ex_sr1_d;
      ex_sr2_q      <= ex_sr2_d;
      ex_sr1_addr_q <= ex_sr1_addr_d;
      ex_sr2_addr_q <= ex_sr2_addr_d;
      ex_dest_q     <= ex_dest_d;
      ex_dest_we_q  <= ex_dest_we_d;
      ex_is_load_q  <= ex_is_load_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_opcode   = ex_opcode_q;
  assign ex_sr1      = ex_sr1_q;
  assign ex_sr2      = ex_sr2_q;
  assign ex_sr1_addr = ex_sr1_addr_q;
  assign ex_sr2_addr = ex_sr2_addr_q;
  assign ex_dest     = ex_dest_q;
  assign ex_dest_we  = ex_dest_we_q;
  assign ex_is_load  = ex_is_load_q;

endmodule
